gpu_cmd_tx: RTL

// - CPU-side transmitter for the GPU text-mode command line (cpuline). Accepts high-level text

---
 rtl/gpu_cmd_tx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/gpu_cmd_tx.sv
// gpu_cmd_tx: buffers text requests in a small FIFO and serialises them onto cpuline as CMD/PARAM/EXEC slots.
// Defining GPU_CURSOR_SHADOW_EN adds cursor_x/cursor_y, which shadow the GPU's text cursor.
module gpu_cmd_tx #(
  parameter int FIFO_AW = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_arg,
  output logic [15:0] cpuline,
  output logic        busy,
  output logic        err_op
`ifdef GPU_CURSOR_SHADOW_EN
  ,
  output logic [11:0] cursor_x,
  output logic [11:0] cursor_y
`endif
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {SLOT_CMD, SLOT_PARAM, SLOT_EXEC} slot_e;

  logic [18:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  slot_e              slot_q, slot_d;
  logic               active_q, active_d;
  logic [2:0]         op_q, op_d;
  logic [15:0]        param_q, param_d;
  logic [15:0]        cpuline_q, cpuline_d;
  logic               err_q, err_d;

  logic        accept, legal, push, load_cmd, pop;
  logic [18:0] head;
  logic [2:0]  head_op;

  assign req_ready = (count_q != FULL_CNT);
  assign accept    = req_valid && req_ready;
  assign legal     = (req_op != 3'd0) && (req_op != 3'd7);
  assign push      = accept && legal;
  // The edge that opens the next CMD slot is the only place a queued entry may leave.
  assign load_cmd  = (slot_q == SLOT_EXEC) || ((slot_q == SLOT_PARAM) && !active_q);
  assign pop       = load_cmd && (count_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign head_op   = head[18:16];

  assign cpuline = cpuline_q;
  assign busy    = (count_q != '0) || active_q;
  assign err_op  = err_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_op, req_arg};
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q + FIFO_AW'(push);
    rd_ptr_d  = rd_ptr_q + FIFO_AW'(pop);
    count_d   = count_q + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
    err_d     = accept && !legal;
    slot_d    = slot_q;
    active_d  = active_q;
    op_d      = op_q;
    param_d   = param_q;
    cpuline_d = 16'h0000;
    case (slot_q)
      SLOT_CMD: begin
        slot_d    = SLOT_PARAM;
        cpuline_d = active_q ? param_q : 16'h0000;
      end
      SLOT_PARAM: slot_d = active_q ? SLOT_EXEC : SLOT_CMD;
      default:    slot_d = SLOT_CMD;
    endcase
    if (load_cmd) begin
      active_d = pop;
      if (pop) begin
        op_d      = head_op;
        param_d   = ((head_op == 3'd1) || (head_op == 3'd3) || (head_op == 3'd4)) ? head[15:0] : 16'h0000;
        cpuline_d = {13'b0000_0000_1100_0, head_op};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      slot_q    <= SLOT_CMD;
      active_q  <= 1'b0;
      op_q      <= 3'd0;
      param_q   <= 16'h0000;
      cpuline_q <= 16'h0000;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      slot_q    <= slot_d;
      active_q  <= active_d;
      op_q      <= op_d;
      param_q   <= param_d;
      cpuline_q <= cpuline_d;
      err_q     <= err_d;
    end
  end

`ifdef GPU_CURSOR_SHADOW_EN
  logic [11:0] cx_q, cx_d, cy_q, cy_d;

  assign cursor_x = cx_q;
  assign cursor_y = cy_q;

  // Mirrors the GPU's tmpx/tmpy, which it commits as the EXEC slot ends.
  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (slot_q == SLOT_EXEC) begin
      case (op_q)
        3'd1: cx_d = cx_q + 12'd1;
        3'd2: cx_d = cx_q - 12'd1;
        3'd3: cy_d = param_q[11:0];
        3'd4: cx_d = param_q[11:0];
        3'd5: begin
          cx_d = 12'd0;
          cy_d = 12'd0;
        end
        3'd6: begin
          cx_d = 12'd0;
          cy_d = (cy_q > 12'd24) ? 12'd0 : cy_q + 12'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cx_q <= 12'd0;
      cy_q <= 12'd0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end
`endif

endmodule
